// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : aes_pkg
//  Description : Shared AES-128 definitions: FSM state type, round-constant
//                table, GF(2^8) helpers and the S-box function used by both
//                the round datapath and the key schedule.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

  // Iterative core control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Round constants indexed directly by the 4-bit round counter.
  // Entry 0 and entries 11..15 are never used by a legal round and read as 0.
  localparam logic [7:0] c_rcon [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed arithmetically: multiplicative inverse (as x^254, which
  // also maps 0 to 0) followed by the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    // x^254 = x^2 * x^4 * ... * x^128
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes128_iter_core_if.sv
`default_nettype none
// ============================================================================
//  Interface   : aes128_iter_core_if
//  Description : Plaintext/key input handshake and ciphertext output handshake
//                of the iterative AES-128 core.
//  Revision    : 1.0  initial release
//  Signals     : in_valid/in_ready   - input block handshake
//                plaintext, key      - 128-bit input block and cipher key
//                out_valid/out_ready - ciphertext handshake
//                ciphertext          - 128-bit registered result
//                busy                - core is processing or holding a result
//  Modports    : master - block source / ciphertext consumer side
//                slave  - core side
// ============================================================================
interface aes128_iter_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext, busy
  );

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext, busy
  );
endinterface
`default_nettype wire

// File: rtl/aes128_key_step.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_key_step
//  Description : One on-the-fly AES-128 key expansion step (combinational).
//  Revision    : 1.0  initial release
//  Ports       : rk_in  [127:0] current round key, w0 in bits [127:96]
//                rcon   [7:0]   round constant for the round being produced
//                rk_out [127:0] next round key
// ============================================================================
module aes128_key_step
  import aes_pkg::*;
(
  input  wire logic [127:0] rk_in,
  input  wire logic [7:0]   rcon,
  output logic      [127:0] rk_out
);

  logic [31:0] w_rot;
  logic [31:0] w_temp;
  logic [31:0] w_w0;
  logic [31:0] w_w1;
  logic [31:0] w_w2;
  logic [31:0] w_w3;

  // RotWord of w3, then SubWord, then rcon into the top byte.
  assign w_rot  = {rk_in[23:0], rk_in[31:24]};
  assign w_temp = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                   sbox(w_rot[15:8]),  sbox(w_rot[7:0])} ^ {rcon, 24'h000000};

  assign w_w0   = rk_in[127:96] ^ w_temp;
  assign w_w1   = rk_in[95:64]  ^ w_w0;
  assign w_w2   = rk_in[63:32]  ^ w_w1;
  assign w_w3   = rk_in[31:0]   ^ w_w2;

  assign rk_out = {w_w0, w_w1, w_w2, w_w3};

endmodule
`default_nettype wire

// File: rtl/aes_add_round_key.sv
`default_nettype none
// ============================================================================
//  Module      : aes_add_round_key
//  Description : AddRoundKey stage, bitwise XOR of state and round key.
//  Revision    : 1.0  initial release
//  Ports       : din  [127:0] state in
//                rk   [127:0] round key
//                dout [127:0] state out
// ============================================================================
module aes_add_round_key (
  input  wire logic [127:0] din,
  input  wire logic [127:0] rk,
  output logic      [127:0] dout
);

  assign dout = din ^ rk;

endmodule
`default_nettype wire

// File: rtl/aes_mix_col.sv
`default_nettype none
// ============================================================================
//  Module      : aes_mix_col
//  Description : MixColumns stage, fixed 2/3/1/1 circulant per column.
//  Revision    : 1.0  initial release
//  Ports       : din  [127:0] state in
//                dout [127:0] state out
// ============================================================================
module aes_mix_col
  import aes_pkg::*;
(
  input  wire logic [127:0] din,
  output logic      [127:0] dout
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a0;
    logic [7:0] w_a1;
    logic [7:0] w_a2;
    logic [7:0] w_a3;

    assign w_a0 = din[127 - 32*c      -: 8];
    assign w_a1 = din[127 - 32*c - 8  -: 8];
    assign w_a2 = din[127 - 32*c - 16 -: 8];
    assign w_a3 = din[127 - 32*c - 24 -: 8];

    // 3*a is written as xtime(a) ^ a.
    assign dout[127 - 32*c      -: 8] = xtime(w_a0) ^ (xtime(w_a1) ^ w_a1) ^ w_a2 ^ w_a3;
    assign dout[127 - 32*c - 8  -: 8] = w_a0 ^ xtime(w_a1) ^ (xtime(w_a2) ^ w_a2) ^ w_a3;
    assign dout[127 - 32*c - 16 -: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ (xtime(w_a3) ^ w_a3);
    assign dout[127 - 32*c - 24 -: 8] = (xtime(w_a0) ^ w_a0) ^ w_a1 ^ w_a2 ^ xtime(w_a3);
  end

endmodule
`default_nettype wire

// File: rtl/aes_shift_row.sv
`default_nettype none
// ============================================================================
//  Module      : aes_shift_row
//  Description : ShiftRows stage. State byte (row r, column c) lives at index
//                r+4c, bits [127-8*(r+4c) -: 8]; row r rotates left by r.
//  Revision    : 1.0  initial release
//  Ports       : din  [127:0] state in
//                dout [127:0] state out
// ============================================================================
module aes_shift_row (
  input  wire logic [127:0] din,
  output logic      [127:0] dout
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign dout[127 - 8*(r + 4*c) -: 8] = din[127 - 8*(r + 4*((c + r) % 4)) -: 8];
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_sub_byte.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sub_byte
//  Description : SubBytes stage, S-box applied to all 16 state bytes.
//  Revision    : 1.0  initial release
//  Ports       : din  [127:0] state in
//                dout [127:0] state out
// ============================================================================
module aes_sub_byte
  import aes_pkg::*;
(
  input  wire logic [127:0] din,
  output logic      [127:0] dout
);

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
  end

endmodule
`default_nettype wire

// File: rtl/aes128_iter_core.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_iter_core
//  Description : Iterative AES-128 encryption core. One full round per clock
//                over a registered state, round key expanded on the fly, last
//                round skips MixColumns. Valid/ready handshake on both sides.
//  Revision    : 1.0  initial release
//  Parameters  : NR  number of rounds, 1..10 (10 = standard AES-128)
//  Ports       : clk  rising-edge clock
//                rst  synchronous active-high reset
//                bus  aes128_iter_core_if.slave (in_valid, in_ready, plaintext,
//                     key, out_valid, out_ready, ciphertext, busy)
// ============================================================================
module aes128_iter_core
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  wire logic        clk,
  input  wire logic        rst,
  aes128_iter_core_if.slave bus
);

  if ((NR < 1) || (NR > 10)) begin : g_nr_illegal
    $error("aes128_iter_core: NR must be in the range 1..10");
  end

  localparam logic [3:0] c_nr = 4'(NR);

  // Registered state
  state_e       r_fsm;
  logic [127:0] r_state;
  logic [127:0] r_rk;
  logic [3:0]   r_rnd;
  logic [127:0] r_ct;

  // Next-state values
  state_e       w_fsm_nxt;
  logic [127:0] w_state_nxt;
  logic [127:0] w_rk_nxt;
  logic [3:0]   w_rnd_nxt;
  logic [127:0] w_ct_nxt;

  // Outputs decoded from the state register
  logic         w_in_ready;
  logic         w_out_valid;
  logic         w_busy;

  // Round datapath
  logic [7:0]   w_rcon;
  logic [127:0] w_next_rk;
  logic [127:0] w_sb;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] w_pre_ark;
  logic [127:0] w_round;
  logic         w_last;

  assign w_rcon = c_rcon[r_rnd];
  assign w_last = (r_rnd == c_nr);

  aes128_key_step u_key_step (
    .rk_in  (r_rk),
    .rcon   (w_rcon),
    .rk_out (w_next_rk)
  );

  aes_sub_byte u_sub_byte (
    .din  (r_state),
    .dout (w_sb)
  );

  aes_shift_row u_shift_row (
    .din  (w_sb),
    .dout (w_sr)
  );

  aes_mix_col u_mix_col (
    .din  (w_sr),
    .dout (w_mc)
  );

  // Final round bypasses MixColumns.
  assign w_pre_ark = w_last ? w_sr : w_mc;

  aes_add_round_key u_add_round_key (
    .din  (w_pre_ark),
    .rk   (w_next_rk),
    .dout (w_round)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm   <= IDLE;
      r_state <= '0;
      r_rk    <= '0;
      r_rnd   <= '0;
      r_ct    <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_rk    <= w_rk_nxt;
      r_rnd   <= w_rnd_nxt;
      r_ct    <= w_ct_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_rk_nxt    = r_rk;
    w_rnd_nxt   = r_rnd;
    w_ct_nxt    = r_ct;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;

    case (r_fsm)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          // Initial AddRoundKey with the cipher key itself.
          w_state_nxt = bus.plaintext ^ bus.key;
          w_rk_nxt    = bus.key;
          w_rnd_nxt   = 4'd1;
          w_fsm_nxt   = RUN;
        end
      end

      RUN: begin
        w_busy      = 1'b1;
        w_state_nxt = w_round;
        w_rk_nxt    = w_next_rk;
        // Stops at NR+1 at most, so the 4-bit counter never wraps.
        w_rnd_nxt   = r_rnd + 4'd1;
        if (w_last) begin
          w_ct_nxt  = w_round;
          w_fsm_nxt = DONE;
        end
      end

      DONE: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        // New blocks are only taken from IDLE, so even with in_valid
        // present here the next block waits one cycle.
        if (bus.out_ready) begin
          w_fsm_nxt = IDLE;
        end
      end

      default: begin
        w_fsm_nxt = IDLE;
      end
    endcase
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.busy       = w_busy;
  assign bus.ciphertext = r_ct;

endmodule
`default_nettype wire

// File: tb/tb_aes128_iter_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes128_iter_core
//  Description : Self-checking bench for aes128_iter_core (NR=10 and NR=1
//                builds) against a byte-level AES reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes128_iter_core;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  aes128_iter_core_if if10 ();
  aes128_iter_core_if if1 ();

  aes128_iter_core #(.NR(10)) dut10 (.clk(clk), .rst(rst), .bus(if10.slave));
  aes128_iter_core #(.NR(1))  dut1  (.clk(clk), .rst(rst), .bus(if1.slave));

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // ---------------- reference AES model ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  // S-box table: inverse by exhaustive search, then affine transform.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k, input int nr);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = tb_gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ k[127 - 8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++) t[row + 4*c] = s[row + 4*((c + row) % 4)];
      for (int c = 0; c < 4; c++) begin
        if (r < nr) begin
          s[4*c]   = tb_gmul(t[4*c], 2) ^ tb_gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ tb_gmul(t[4*c+1], 2) ^ tb_gmul(t[4*c+2], 3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ tb_gmul(t[4*c+2], 2) ^ tb_gmul(t[4*c+3], 3);
          s[4*c+3] = tb_gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ tb_gmul(t[4*c+3], 2);
        end else begin
          for (int row = 0; row < 4; row++) s[4*c + row] = t[4*c + row];
        end
        for (int row = 0; row < 4; row++) s[4*c + row] = s[4*c + row] ^ w[4*r + c][31 - 8*row -: 8];
      end
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- transaction-level timing model ----------------
  // Accepted block -> result visible nr cycles later, held until taken.
  logic [127:0] m_ct   [2];
  logic [127:0] m_pend [2];
  int           m_cnt  [2];
  bit           m_run  [2];
  bit           m_ov   [2];

  task automatic model_step(input int k, input int nr, input logic iv, input logic ordy,
                            input logic [127:0] pt, input logic [127:0] kk);
    if (rst) begin
      m_ct[k] <= '0; m_run[k] <= 1'b0; m_ov[k] <= 1'b0; m_cnt[k] <= 0;
    end else if (m_ov[k]) begin
      if (ordy) m_ov[k] <= 1'b0;
    end else if (m_run[k]) begin
      m_cnt[k] <= m_cnt[k] - 1;
      if (m_cnt[k] == 1) begin
        m_run[k] <= 1'b0; m_ov[k] <= 1'b1; m_ct[k] <= m_pend[k];
      end
    end else if (iv) begin
      m_run[k] <= 1'b1; m_cnt[k] <= nr; m_pend[k] <= aes_ref(pt, kk, nr);
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 10, if10.in_valid, if10.out_ready, if10.plaintext, if10.key);
    model_step(1, 1,  if1.in_valid,  if1.out_ready,  if1.plaintext,  if1.key);
  end

  // ---------------- check helpers ----------------
  task automatic chk128(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %032h required %032h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic chk_live(input int k, input logic ir, input logic ov, input logic bz, input logic [127:0] ct);
    logic e_ir, e_ov, e_bz;
    e_ir = !(m_run[k] || m_ov[k]);
    e_ov = m_ov[k];
    e_bz = m_run[k] || m_ov[k];
    n_cmp++;
    if (ir !== e_ir || ov !== e_ov || bz !== e_bz || ct !== m_ct[k]) begin
      n_fail++;
      $display("FAIL live dut%0d cyc %0d: got ir=%b ov=%b busy=%b ct=%032h required ir=%b ov=%b busy=%b ct=%032h",
               k, cyc, ir, ov, bz, ct, e_ir, e_ov, e_bz, m_ct[k]);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input int k, input logic v, input logic [127:0] pt, input logic [127:0] kk);
    if (k == 0) begin if10.in_valid = v; if10.plaintext = pt; if10.key = kk; end
    else        begin if1.in_valid  = v; if1.plaintext  = pt; if1.key  = kk; end
  endtask

  // Offers a block until accepted; returns at the negedge of the accepting
  // cycle with in_valid still high.
  task automatic send(input int k, input logic [127:0] pt, input logic [127:0] kk, output int acc);
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      set_in(k, 1'b1, pt, kk);
      if ((k == 0) ? if10.in_ready : if1.in_ready) begin
        acc = cyc;
        return;
      end
    end
    n_cmp++; n_fail++;
    $display("FAIL send_timeout dut%0d: got no in_ready required in_ready=1", k);
  endtask

  task automatic wait_ov(input int k, output int t);
    t = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      set_in(k, 1'b0, '0, '0);
      if ((k == 0) ? if10.out_valid : if1.out_valid) begin
        t = cyc;
        return;
      end
    end
    n_cmp++; n_fail++;
    $display("FAIL ov_timeout dut%0d: got out_valid=0 required out_valid=1", k);
  endtask

  // ---------------- main ----------------
  initial begin
    int a, a2, t;
    set_in(0, 1'b0, '0, '0);
    set_in(1, 1'b0, '0, '0);
    if10.out_ready = 1'b1;
    if1.out_ready  = 1'b1;
    build_sbox();

    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          chk_live(0, if10.in_ready, if10.out_valid, if10.busy, if10.ciphertext);
          chk_live(1, if1.in_ready,  if1.out_valid,  if1.busy,  if1.ciphertext);
        end
      end

      begin
        // Model pins
        chk_int("sbox_00", int'(sbox_t[8'h00]), 'h63);
        chk_int("sbox_53", int'(sbox_t[8'h53]), 'hed);
        chk128("model_c1", aes_ref(C1_PT, C1_KEY, 10), C1_CT);
        chk128("model_b",  aes_ref(B_PT,  B_KEY,  10), B_CT);

        // Reset state
        repeat (3) @(negedge clk);
        chk_int("rst_in_ready",  int'(if10.in_ready), 1);
        chk_int("rst_out_valid", int'(if10.out_valid), 0);
        chk_int("rst_busy",      int'(if10.busy), 0);
        chk128("rst_ct",        if10.ciphertext, '0);
        chk128("rst_state_reg", dut10.r_state, '0);
        chk128("rst_rk_reg",    dut10.r_rk, '0);
        chk_int("rst_rnd",      int'(dut10.r_rnd), 0);
        chk_en = 1'b1;
        rst    = 1'b0;

        // FIPS-197 C.1 with latency
        send(0, C1_PT, C1_KEY, a);
        wait_ov(0, t);
        chk_int("c1_latency", t - a, 11);
        chk128("c1_ct", if10.ciphertext, C1_CT);

        // FIPS-197 App. B with round-1 key
        send(0, B_PT, B_KEY, a);
        @(negedge clk); set_in(0, 1'b0, '0, '0);
        @(negedge clk);
        chk128("b_rk_round1", dut10.r_rk, B_RK1);
        wait_ov(0, t);
        chk128("b_ct", if10.ciphertext, B_CT);

        // Backpressure with an ignored in_valid pulse
        @(negedge clk); if10.out_ready = 1'b0;
        send(0, C1_PT, C1_KEY, a);
        wait_ov(0, t);
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          set_in(0, (i >= 3 && i <= 5), B_PT, B_KEY);
          chk128("bp_ct_stable", if10.ciphertext, C1_CT);
          chk_int("bp_out_valid", int'(if10.out_valid), 1);
          chk_int("bp_in_ready",  int'(if10.in_ready), 0);
        end
        @(negedge clk); set_in(0, 1'b0, '0, '0); if10.out_ready = 1'b1;
        @(negedge clk); if10.out_ready = 1'b0;
        chk_int("bp_release_in_ready", int'(if10.in_ready), 1);

        // Back-to-back
        @(negedge clk); if10.out_ready = 1'b1;
        send(0, C1_PT, C1_KEY, a);
        send(0, B_PT, B_KEY, a2);
        chk_int("b2b_gap", a2 - a, 12);
        chk128("b2b_first_ct", if10.ciphertext, C1_CT);
        wait_ov(0, t);
        chk128("b2b_second_ct", if10.ciphertext, B_CT);

        // Reset in cycle 5 of RUN
        @(negedge clk);
        send(0, C1_PT, C1_KEY, a);
        @(negedge clk); set_in(0, 1'b0, '0, '0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_int("mid_rst_out_valid", int'(if10.out_valid), 0);
        chk128("mid_rst_ct", if10.ciphertext, '0);
        chk_int("mid_rst_in_ready", int'(if10.in_ready), 1);
        rst = 1'b0;
        send(0, C1_PT, C1_KEY, a);
        wait_ov(0, t);
        chk_int("post_rst_latency", t - a, 11);
        chk128("post_rst_ct", if10.ciphertext, C1_CT);

        // NR=1 build
        send(1, B_PT, B_KEY, a);
        wait_ov(1, t);
        chk_int("nr1_latency", t - a, 2);
        chk128("nr1_ct", if1.ciphertext, aes_ref(B_PT, B_KEY, 1));

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
      end
    join_any
  end

endmodule
`default_nettype wire
